// File: rtl/tl_rx_vc_multi_buffer_ctrl.sv
// Purpose: per-queue header/data pointer control for one RX VC with speculative writes, commit/rollback at eop.
// Latency: RAM write enables/addresses combinational; commit, rollback and read pops visible one cycle later.
// Backpressure: none upstream; full queues drop the TLP (o_ovf_err at eop), empty queues ignore read pops.
module tl_rx_vc_multi_buffer_ctrl #(
  parameter int NUM_CH  = 3,
  parameter int HDR_AW  = 7,
  parameter int DATA_AW = 10,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_n_rst,
  input  logic [CH_W-1:0]                   i_w_ch,
  input  logic                              i_w_sop,
  input  logic                              i_w_data_valid,
  input  logic                              i_w_eop,
  input  logic                              i_w_good,
  output logic                              o_w_hdr_en,
  output logic                              o_w_data_en,
  output logic [CH_W+HDR_AW-1:0]            o_w_hdr_addr,
  output logic [CH_W+DATA_AW-1:0]           o_w_data_addr,
  output logic                              o_ovf_err,
  input  logic [NUM_CH-1:0]                 i_r_hdr_inc,
  input  logic [NUM_CH-1:0]                 i_r_data_inc,
  output logic [NUM_CH*HDR_AW-1:0]          o_r_hdr_addr,
  output logic [NUM_CH*DATA_AW-1:0]         o_r_data_addr,
  output logic [NUM_CH-1:0]                 o_hdr_empty,
  output logic [NUM_CH-1:0]                 o_hdr_full,
  output logic [NUM_CH-1:0]                 o_data_empty,
  output logic [NUM_CH-1:0]                 o_data_full,
  output logic [NUM_CH*(DATA_AW+1)-1:0]     o_data_free,
  output logic [NUM_CH-1:0]                 o_fc_hdr_rel,
  output logic [NUM_CH-1:0]                 o_fc_data_rel
);

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_ACTIVE = 2'd1;
  localparam logic [1:0] W_DROP   = 2'd2;

  localparam logic [HDR_AW:0]  HDR_ONE    = {{HDR_AW{1'b0}}, 1'b1};
  localparam logic [DATA_AW:0] DATA_ONE   = {{DATA_AW{1'b0}}, 1'b1};
  localparam logic [DATA_AW:0] DATA_DEPTH = {1'b1, {DATA_AW{1'b0}}};

  // Per-queue pointers: committed write, speculative write, read.
  logic [HDR_AW:0]  r_wc_hdr  [NUM_CH];
  logic [HDR_AW:0]  r_ws_hdr  [NUM_CH];
  logic [HDR_AW:0]  r_rd_hdr  [NUM_CH];
  logic [DATA_AW:0] r_wc_data [NUM_CH];
  logic [DATA_AW:0] r_ws_data [NUM_CH];
  logic [DATA_AW:0] r_rd_data [NUM_CH];

  logic [1:0]        r_state;
  logic [CH_W-1:0]   r_ch;
  logic              r_ovf;
  logic [NUM_CH-1:0] r_fc_hdr_rel;
  logic [NUM_CH-1:0] r_fc_data_rel;

  logic [NUM_CH-1:0] w_hdr_full;
  logic [NUM_CH-1:0] w_data_full;
  logic [NUM_CH-1:0] w_hdr_empty;
  logic [NUM_CH-1:0] w_data_empty;
  logic [NUM_CH-1:0] w_hdr_pop;
  logic [NUM_CH-1:0] w_data_pop;

  logic [CH_W-1:0]   w_ch_sel;
  logic [NUM_CH-1:0] w_q_sel;
  logic [HDR_AW:0]   w_sel_ws_hdr;
  logic [DATA_AW:0]  w_sel_ws_data;
  logic              w_sel_hdr_full;
  logic              w_sel_data_full;
  logic [HDR_AW:0]   w_ws_hdr_nxt;
  logic [DATA_AW:0]  w_ws_data_nxt;

  logic w_sop_acc;
  logic w_hdr_en;
  logic w_hdr_ovf;
  logic w_data_try;
  logic w_data_en;
  logic w_data_ovf;
  logic w_ovf_now;
  logic w_eop_acc;
  logic w_commit;
  logic w_rollback;

  // Per-queue flags: full against the speculative pointer, empty against the committed one.
  always_comb begin
    w_hdr_full    = '0;
    w_data_full   = '0;
    w_hdr_empty   = '0;
    w_data_empty  = '0;
    w_hdr_pop     = '0;
    w_data_pop    = '0;
    o_data_free   = '0;
    o_r_hdr_addr  = '0;
    o_r_data_addr = '0;
    for (int q = 0; q < NUM_CH; q++) begin
      w_hdr_full[q]   = (r_ws_hdr[q][HDR_AW] != r_rd_hdr[q][HDR_AW]) &&
                        (r_ws_hdr[q][HDR_AW-1:0] == r_rd_hdr[q][HDR_AW-1:0]);
      w_data_full[q]  = (r_ws_data[q][DATA_AW] != r_rd_data[q][DATA_AW]) &&
                        (r_ws_data[q][DATA_AW-1:0] == r_rd_data[q][DATA_AW-1:0]);
      w_hdr_empty[q]  = (r_wc_hdr[q] == r_rd_hdr[q]);
      w_data_empty[q] = (r_wc_data[q] == r_rd_data[q]);
      w_hdr_pop[q]    = i_r_hdr_inc[q] && !w_hdr_empty[q];
      w_data_pop[q]   = i_r_data_inc[q] && !w_data_empty[q];
      o_data_free[q*(DATA_AW+1) +: DATA_AW+1] = DATA_DEPTH - (r_ws_data[q] - r_rd_data[q]);
      o_r_hdr_addr[q*HDR_AW +: HDR_AW]    = r_rd_hdr[q][HDR_AW-1:0];
      o_r_data_addr[q*DATA_AW +: DATA_AW] = r_rd_data[q][DATA_AW-1:0];
    end
  end

  // Select the active queue's write state; an out-of-range queue index looks full so the TLP is dropped.
  always_comb begin
    w_ch_sel        = (r_state == W_IDLE) ? i_w_ch : r_ch;
    w_q_sel         = '0;
    w_sel_ws_hdr    = '0;
    w_sel_ws_data   = '0;
    w_sel_hdr_full  = 1'b1;
    w_sel_data_full = 1'b1;
    for (int q = 0; q < NUM_CH; q++) begin
      if (w_ch_sel == CH_W'(q)) begin
        w_q_sel[q]      = 1'b1;
        w_sel_ws_hdr    = r_ws_hdr[q];
        w_sel_ws_data   = r_ws_data[q];
        w_sel_hdr_full  = w_hdr_full[q];
        w_sel_data_full = w_data_full[q];
      end
    end
  end

  assign w_sop_acc  = (r_state == W_IDLE) && i_w_sop;
  assign w_hdr_en   = w_sop_acc && !w_sel_hdr_full;
  assign w_hdr_ovf  = w_sop_acc && w_sel_hdr_full;
  assign w_data_try = (r_state == W_ACTIVE) && i_w_data_valid;
  assign w_data_en  = w_data_try && !w_sel_data_full;
  assign w_data_ovf = w_data_try && w_sel_data_full;
  // Overflow in the eop cycle itself must also force a rollback.
  assign w_ovf_now  = ((r_state != W_IDLE) && r_ovf) || w_hdr_ovf || w_data_ovf;
  assign w_eop_acc  = i_w_eop && ((r_state != W_IDLE) || i_w_sop);
  assign w_commit   = w_eop_acc && i_w_good && !w_ovf_now;
  assign w_rollback = w_eop_acc && !w_commit;

  assign w_ws_hdr_nxt  = w_sel_ws_hdr  + {{HDR_AW{1'b0}}, w_hdr_en};
  assign w_ws_data_nxt = w_sel_ws_data + {{DATA_AW{1'b0}}, w_data_en};

  assign o_w_hdr_en    = w_hdr_en;
  assign o_w_data_en   = w_data_en;
  assign o_w_hdr_addr  = {w_ch_sel, w_sel_ws_hdr[HDR_AW-1:0]};
  assign o_w_data_addr = {w_ch_sel, w_sel_ws_data[DATA_AW-1:0]};
  assign o_ovf_err     = w_eop_acc && w_ovf_now;
  assign o_hdr_empty   = w_hdr_empty;
  assign o_hdr_full    = w_hdr_full;
  assign o_data_empty  = w_data_empty;
  assign o_data_full   = w_data_full;
  assign o_fc_hdr_rel  = r_fc_hdr_rel;
  assign o_fc_data_rel = r_fc_data_rel;

  // Write FSM: eop always returns to idle; sop latches the queue and picks accept or drop.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_state <= W_IDLE;
      r_ch    <= '0;
      r_ovf   <= 1'b0;
    end else if (w_eop_acc) begin
      r_state <= W_IDLE;
      r_ovf   <= 1'b0;
    end else if (w_sop_acc) begin
      r_ch    <= i_w_ch;
      r_ovf   <= w_hdr_ovf;
      r_state <= w_hdr_ovf ? W_DROP : W_ACTIVE;
    end else if (w_data_ovf) begin
      r_ovf   <= 1'b1;
      r_state <= W_DROP;
    end
  end

  // Pointer updates: speculative advance, commit/rollback on eop, independent read pops.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      for (int q = 0; q < NUM_CH; q++) begin
        r_wc_hdr[q]  <= '0;
        r_ws_hdr[q]  <= '0;
        r_rd_hdr[q]  <= '0;
        r_wc_data[q] <= '0;
        r_ws_data[q] <= '0;
        r_rd_data[q] <= '0;
      end
    end else begin
      for (int q = 0; q < NUM_CH; q++) begin
        if (w_q_sel[q]) begin
          if (w_rollback) begin
            r_ws_hdr[q]  <= r_wc_hdr[q];
            r_ws_data[q] <= r_wc_data[q];
          end else begin
            r_ws_hdr[q]  <= w_ws_hdr_nxt;
            r_ws_data[q] <= w_ws_data_nxt;
          end
          if (w_commit) begin
            r_wc_hdr[q]  <= w_ws_hdr_nxt;
            r_wc_data[q] <= w_ws_data_nxt;
          end
        end
        if (w_hdr_pop[q]) begin
          r_rd_hdr[q] <= r_rd_hdr[q] + HDR_ONE;
        end
        if (w_data_pop[q]) begin
          r_rd_data[q] <= r_rd_data[q] + DATA_ONE;
        end
      end
    end
  end

  // Credit return pulses, one per accepted pop, registered.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_fc_hdr_rel  <= '0;
      r_fc_data_rel <= '0;
    end else begin
      r_fc_hdr_rel  <= w_hdr_pop;
      r_fc_data_rel <= w_data_pop;
    end
  end

endmodule

// File: tb/tb_tl_rx_vc_multi_buffer_ctrl.sv
// Bench for tl_rx_vc_multi_buffer_ctrl: scenario tasks drive TLPs and pops,
// expected RAM write addresses go through a scoreboard compared at the negedge.
// Pointer model is kept in plain integers, wrapped modulo 2^(AW+1).
module tb_tl_rx_vc_multi_buffer_ctrl;
  localparam int NUM_CH  = 3;
  localparam int HDR_AW  = 7;
  localparam int DATA_AW = 10;
  localparam int CH_W    = 2;

  logic                          i_clk = 1'b0;
  logic                          i_n_rst;
  logic [CH_W-1:0]               i_w_ch;
  logic                          i_w_sop;
  logic                          i_w_data_valid;
  logic                          i_w_eop;
  logic                          i_w_good;
  logic                          o_w_hdr_en;
  logic                          o_w_data_en;
  logic [CH_W+HDR_AW-1:0]        o_w_hdr_addr;
  logic [CH_W+DATA_AW-1:0]       o_w_data_addr;
  logic                          o_ovf_err;
  logic [NUM_CH-1:0]             i_r_hdr_inc;
  logic [NUM_CH-1:0]             i_r_data_inc;
  logic [NUM_CH*HDR_AW-1:0]      o_r_hdr_addr;
  logic [NUM_CH*DATA_AW-1:0]     o_r_data_addr;
  logic [NUM_CH-1:0]             o_hdr_empty;
  logic [NUM_CH-1:0]             o_hdr_full;
  logic [NUM_CH-1:0]             o_data_empty;
  logic [NUM_CH-1:0]             o_data_full;
  logic [NUM_CH*(DATA_AW+1)-1:0] o_data_free;
  logic [NUM_CH-1:0]             o_fc_hdr_rel;
  logic [NUM_CH-1:0]             o_fc_data_rel;

  tl_rx_vc_multi_buffer_ctrl #(.NUM_CH(NUM_CH), .HDR_AW(HDR_AW), .DATA_AW(DATA_AW)) dut (
    .i_clk(i_clk), .i_n_rst(i_n_rst), .i_w_ch(i_w_ch), .i_w_sop(i_w_sop),
    .i_w_data_valid(i_w_data_valid), .i_w_eop(i_w_eop), .i_w_good(i_w_good),
    .o_w_hdr_en(o_w_hdr_en), .o_w_data_en(o_w_data_en), .o_w_hdr_addr(o_w_hdr_addr),
    .o_w_data_addr(o_w_data_addr), .o_ovf_err(o_ovf_err), .i_r_hdr_inc(i_r_hdr_inc),
    .i_r_data_inc(i_r_data_inc), .o_r_hdr_addr(o_r_hdr_addr), .o_r_data_addr(o_r_data_addr),
    .o_hdr_empty(o_hdr_empty), .o_hdr_full(o_hdr_full), .o_data_empty(o_data_empty),
    .o_data_full(o_data_full), .o_data_free(o_data_free), .o_fc_hdr_rel(o_fc_hdr_rel),
    .o_fc_data_rel(o_fc_data_rel)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  logic [CH_W+HDR_AW-1:0]  exp_hdr_q  [$];
  logic [CH_W+DATA_AW-1:0] exp_data_q [$];
  logic [CH_W+HDR_AW-1:0]  mon_eh;
  logic [CH_W+DATA_AW-1:0] mon_ed;

  int m_ws_hdr  [NUM_CH];
  int m_wc_hdr  [NUM_CH];
  int m_rd_hdr  [NUM_CH];
  int m_ws_data [NUM_CH];
  int m_wc_data [NUM_CH];
  int m_rd_data [NUM_CH];
  int fc_hdr_cnt  [NUM_CH];
  int fc_data_cnt [NUM_CH];

  function automatic bit m_hdr_full(input int ch);
    return ((m_ws_hdr[ch] - m_rd_hdr[ch]) & 255) == 128;
  endfunction

  function automatic bit m_data_full(input int ch);
    return ((m_ws_data[ch] - m_rd_data[ch]) & 2047) == 1024;
  endfunction

  // Scoreboard: every RAM write enable must match the next expected address.
  always @(negedge i_clk) begin
    if (i_n_rst) begin
      if (o_w_hdr_en) begin
        checks++;
        if (exp_hdr_q.size() == 0) begin
          failures++;
          $display("FAIL hdr_wr_unexpected got_addr=%0h exp=no_write", o_w_hdr_addr);
        end else begin
          mon_eh = exp_hdr_q.pop_front();
          if (o_w_hdr_addr !== mon_eh) begin
            failures++;
            $display("FAIL hdr_wr_addr got=%0h exp=%0h", o_w_hdr_addr, mon_eh);
          end
        end
      end
      if (o_w_data_en) begin
        checks++;
        if (exp_data_q.size() == 0) begin
          failures++;
          $display("FAIL data_wr_unexpected got_addr=%0h exp=no_write", o_w_data_addr);
        end else begin
          mon_ed = exp_data_q.pop_front();
          if (o_w_data_addr !== mon_ed) begin
            failures++;
            $display("FAIL data_wr_addr got=%0h exp=%0h", o_w_data_addr, mon_ed);
          end
        end
      end
      for (int q = 0; q < NUM_CH; q++) begin
        if (o_fc_hdr_rel[q] === 1'b1) fc_hdr_cnt[q]++;
        if (o_fc_data_rel[q] === 1'b1) fc_data_cnt[q]++;
      end
    end
  end

  task automatic idle_inputs();
    i_w_ch = '0; i_w_sop = 1'b0; i_w_data_valid = 1'b0; i_w_eop = 1'b0; i_w_good = 1'b0;
    i_r_hdr_inc = '0; i_r_data_inc = '0;
  endtask

  task automatic m_clear();
    for (int q = 0; q < NUM_CH; q++) begin
      m_ws_hdr[q] = 0; m_wc_hdr[q] = 0; m_rd_hdr[q] = 0;
      m_ws_data[q] = 0; m_wc_data[q] = 0; m_rd_data[q] = 0;
      fc_hdr_cnt[q] = 0; fc_data_cnt[q] = 0;
    end
    exp_hdr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic do_reset();
    i_n_rst = 1'b0;
    idle_inputs();
    m_clear();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_n_rst = 1'b1;
    @(posedge i_clk); #1;
  endtask

  // One TLP: sop cycle, then ndata data cycles with eop on the last (sop+eop when ndata==0).
  task automatic send_tlp(input int ch, input int ndata, input bit good, output bit got_ovf);
    bit drop;
    drop = 1'b0;
    got_ovf = 1'b0;
    i_w_ch = CH_W'(ch); i_w_sop = 1'b1; i_w_good = good; i_w_eop = (ndata == 0);
    if (m_hdr_full(ch)) drop = 1'b1;
    else begin
      exp_hdr_q.push_back({CH_W'(ch), HDR_AW'(m_ws_hdr[ch])});
      m_ws_hdr[ch] = (m_ws_hdr[ch] + 1) & 255;
    end
    @(negedge i_clk);
    if (ndata == 0) got_ovf = o_ovf_err;
    @(posedge i_clk); #1;
    i_w_sop = 1'b0;
    for (int k = 0; k < ndata; k++) begin
      i_w_data_valid = 1'b1;
      i_w_eop = (k == ndata - 1);
      if (!drop) begin
        if (m_data_full(ch)) drop = 1'b1;
        else begin
          exp_data_q.push_back({CH_W'(ch), DATA_AW'(m_ws_data[ch])});
          m_ws_data[ch] = (m_ws_data[ch] + 1) & 2047;
        end
      end
      @(negedge i_clk);
      if (k == ndata - 1) got_ovf = o_ovf_err;
      @(posedge i_clk); #1;
    end
    i_w_data_valid = 1'b0; i_w_eop = 1'b0; i_w_good = 1'b0;
    if (good && !drop) begin
      m_wc_hdr[ch] = m_ws_hdr[ch]; m_wc_data[ch] = m_ws_data[ch];
    end else begin
      m_ws_hdr[ch] = m_wc_hdr[ch]; m_ws_data[ch] = m_wc_data[ch];
    end
  endtask

  task automatic pop(input logic [NUM_CH-1:0] hm, input logic [NUM_CH-1:0] dm);
    i_r_hdr_inc = hm; i_r_data_inc = dm;
    for (int q = 0; q < NUM_CH; q++) begin
      if (hm[q] && m_wc_hdr[q] != m_rd_hdr[q]) m_rd_hdr[q] = (m_rd_hdr[q] + 1) & 255;
      if (dm[q] && m_wc_data[q] != m_rd_data[q]) m_rd_data[q] = (m_rd_data[q] + 1) & 2047;
    end
    @(posedge i_clk); #1;
    i_r_hdr_inc = '0; i_r_data_inc = '0;
  endtask

  task automatic test_reset();
    i_n_rst = 1'b0;
    idle_inputs();
    m_clear();
    #3;
    checks++; if (o_hdr_empty !== 3'b111) begin failures++; $display("FAIL rst_hdr_empty got=%b exp=111", o_hdr_empty); end
    checks++; if (o_data_empty !== 3'b111) begin failures++; $display("FAIL rst_data_empty got=%b exp=111", o_data_empty); end
    checks++; if (o_hdr_full !== 3'b000 || o_data_full !== 3'b000) begin failures++; $display("FAIL rst_full got=%b/%b exp=000/000", o_hdr_full, o_data_full); end
    checks++; if (o_data_free !== {3{11'd1024}}) begin failures++; $display("FAIL rst_free got=%h exp=%h", o_data_free, {3{11'd1024}}); end
    checks++; if (o_w_hdr_en !== 1'b0 || o_w_data_en !== 1'b0 || o_ovf_err !== 1'b0) begin failures++; $display("FAIL rst_en got=%b%b%b exp=000", o_w_hdr_en, o_w_data_en, o_ovf_err); end
    checks++; if (o_fc_hdr_rel !== 3'b000 || o_fc_data_rel !== 3'b000) begin failures++; $display("FAIL rst_fc got=%b/%b exp=000/000", o_fc_hdr_rel, o_fc_data_rel); end
    @(negedge i_clk);
    i_n_rst = 1'b1;
    @(posedge i_clk); #1;
    checks++; if (o_r_hdr_addr !== '0 || o_r_data_addr !== '0) begin failures++; $display("FAIL rst_rd_addr got=%h/%h exp=0/0", o_r_hdr_addr, o_r_data_addr); end
  endtask

  task automatic test_commit();
    bit ov;
    send_tlp(1, 3, 1'b1, ov);
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL commit_ovf got=%b exp=0", ov); end
    checks++; if (o_hdr_empty[1] !== 1'b0) begin failures++; $display("FAIL commit_hdr_empty got=%b exp=0", o_hdr_empty[1]); end
    checks++; if (o_data_empty[1] !== 1'b0) begin failures++; $display("FAIL commit_data_empty got=%b exp=0", o_data_empty[1]); end
    checks++; if (o_data_free[11 +: 11] !== 11'd1021) begin failures++; $display("FAIL commit_free got=%0d exp=1021", o_data_free[11 +: 11]); end
    checks++; if (exp_hdr_q.size() != 0 || exp_data_q.size() != 0) begin failures++; $display("FAIL commit_drain got=%0d/%0d exp=0/0", exp_hdr_q.size(), exp_data_q.size()); end
  endtask

  task automatic test_rollback();
    bit ov;
    send_tlp(0, 4, 1'b0, ov);
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL rb_ovf got=%b exp=0", ov); end
    checks++; if (o_hdr_empty !== 3'b101 || o_data_empty !== 3'b101) begin failures++; $display("FAIL rb_empty got=%b/%b exp=101/101", o_hdr_empty, o_data_empty); end
    checks++; if (o_data_free[0 +: 11] !== 11'd1024) begin failures++; $display("FAIL rb_free got=%0d exp=1024", o_data_free[0 +: 11]); end
    send_tlp(0, 1, 1'b1, ov);
    checks++; if (o_hdr_empty[0] !== 1'b0 || o_data_free[0 +: 11] !== 11'd1023) begin failures++; $display("FAIL rb_next got=%b/%0d exp=0/1023", o_hdr_empty[0], o_data_free[0 +: 11]); end
    checks++; if (exp_hdr_q.size() != 0 || exp_data_q.size() != 0) begin failures++; $display("FAIL rb_drain got=%0d/%0d exp=0/0", exp_hdr_q.size(), exp_data_q.size()); end
  endtask

  task automatic test_hdr_full();
    bit ov;
    do_reset();
    for (int n = 0; n < 128; n++) send_tlp(2, 0, 1'b1, ov);
    checks++; if (o_hdr_full !== 3'b100) begin failures++; $display("FAIL hfull_flag got=%b exp=100", o_hdr_full); end
    send_tlp(2, 0, 1'b1, ov);
    checks++; if (ov !== 1'b1) begin failures++; $display("FAIL hfull_ovf got=%b exp=1", ov); end
    checks++; if (o_hdr_full !== 3'b100 || o_hdr_empty !== 3'b011) begin failures++; $display("FAIL hfull_after got=%b/%b exp=100/011", o_hdr_full, o_hdr_empty); end
    checks++; if (o_data_free !== {3{11'd1024}} || o_data_empty !== 3'b111) begin failures++; $display("FAIL hfull_others got=%h/%b exp=%h/111", o_data_free, o_data_empty, {3{11'd1024}}); end
    checks++; if (exp_hdr_q.size() != 0) begin failures++; $display("FAIL hfull_drain got=%0d exp=0", exp_hdr_q.size()); end
  endtask

  task automatic test_data_full();
    bit ov;
    do_reset();
    send_tlp(0, 1024, 1'b1, ov);
    checks++; if (o_data_full[0] !== 1'b1 || o_data_free[0 +: 11] !== 11'd0) begin failures++; $display("FAIL dfull_flag got=%b/%0d exp=1/0", o_data_full[0], o_data_free[0 +: 11]); end
    pop(3'b000, 3'b001);
    checks++; if (o_fc_data_rel !== 3'b001) begin failures++; $display("FAIL dfull_fc got=%b exp=001", o_fc_data_rel); end
    checks++; if (o_data_full[0] !== 1'b0 || o_data_free[0 +: 11] !== 11'd1) begin failures++; $display("FAIL dfull_pop got=%b/%0d exp=0/1", o_data_full[0], o_data_free[0 +: 11]); end
    send_tlp(0, 2, 1'b1, ov);
    checks++; if (ov !== 1'b1) begin failures++; $display("FAIL dfull_ovf got=%b exp=1", ov); end
    checks++; if (o_data_free[0 +: 11] !== 11'd1 || o_data_full[0] !== 1'b0) begin failures++; $display("FAIL dfull_rb got=%0d/%b exp=1/0", o_data_free[0 +: 11], o_data_full[0]); end
    checks++; if (o_r_data_addr[0 +: DATA_AW] !== 10'd1) begin failures++; $display("FAIL dfull_rdaddr got=%0d exp=1", o_r_data_addr[0 +: DATA_AW]); end
    checks++; if (exp_hdr_q.size() != 0 || exp_data_q.size() != 0) begin failures++; $display("FAIL dfull_drain got=%0d/%0d exp=0/0", exp_hdr_q.size(), exp_data_q.size()); end
  endtask

  task automatic test_wrap();
    bit ov;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      send_tlp(0, 0, 1'b1, ov);
      checks++; if (ov !== 1'b0 || o_hdr_empty[0] !== 1'b0) begin failures++; $display("FAIL wrap_push n=%0d got=%b/%b exp=0/0", n, ov, o_hdr_empty[0]); end
      pop(3'b001, 3'b000);
      checks++; if (o_fc_hdr_rel !== 3'b001 || o_hdr_empty[0] !== 1'b1) begin failures++; $display("FAIL wrap_pop n=%0d got=%b/%b exp=001/1", n, o_fc_hdr_rel, o_hdr_empty[0]); end
    end
    @(negedge i_clk); #1;
    checks++; if (fc_hdr_cnt[0] != 300) begin failures++; $display("FAIL wrap_fc_count got=%0d exp=300", fc_hdr_cnt[0]); end
    checks++; if (o_r_hdr_addr[0 +: HDR_AW] !== 7'd44) begin failures++; $display("FAIL wrap_rdaddr got=%0d exp=44", o_r_hdr_addr[0 +: HDR_AW]); end
    checks++; if (exp_hdr_q.size() != 0) begin failures++; $display("FAIL wrap_drain got=%0d exp=0", exp_hdr_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ov;
    do_reset();
    i_w_ch = 2'd1; i_w_sop = 1'b1;
    exp_hdr_q.push_back({2'd1, 7'd0});
    @(posedge i_clk); #1;
    i_w_sop = 1'b0; i_w_data_valid = 1'b1;
    exp_data_q.push_back({2'd1, 10'd0});
    @(posedge i_clk); #1;
    exp_data_q.push_back({2'd1, 10'd1});
    @(posedge i_clk); #1;
    checks++; if (exp_hdr_q.size() != 0 || exp_data_q.size() != 0) begin failures++; $display("FAIL mid_pre_drain got=%0d/%0d exp=0/0", exp_hdr_q.size(), exp_data_q.size()); end
    i_n_rst = 1'b0;
    #1;
    checks++; if (o_w_data_en !== 1'b0 || o_w_hdr_en !== 1'b0) begin failures++; $display("FAIL mid_en got=%b%b exp=00", o_w_hdr_en, o_w_data_en); end
    checks++; if (o_hdr_empty !== 3'b111 || o_data_empty !== 3'b111) begin failures++; $display("FAIL mid_empty got=%b/%b exp=111/111", o_hdr_empty, o_data_empty); end
    checks++; if (o_data_free !== {3{11'd1024}}) begin failures++; $display("FAIL mid_free got=%h exp=%h", o_data_free, {3{11'd1024}}); end
    idle_inputs();
    m_clear();
    @(negedge i_clk);
    i_n_rst = 1'b1;
    @(posedge i_clk); #1;
    send_tlp(1, 1, 1'b1, ov);
    checks++; if (o_hdr_empty !== 3'b101 || o_data_free[11 +: 11] !== 11'd1023) begin failures++; $display("FAIL mid_after got=%b/%0d exp=101/1023", o_hdr_empty, o_data_free[11 +: 11]); end
    checks++; if (exp_hdr_q.size() != 0 || exp_data_q.size() != 0) begin failures++; $display("FAIL mid_drain got=%0d/%0d exp=0/0", exp_hdr_q.size(), exp_data_q.size()); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_rollback();
    test_hdr_full();
    test_data_full();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_rx_vc_multi_buffer_ctrl.md
# tl_rx_vc_multi_buffer_ctrl

Multi-channel successor of the RX VC buffer control. It owns the header and data pointer registers for NUM_CH receive queues (Posted, Non-Posted and Completion by default) inside one VC. Writes are speculative and are committed or rolled back at end of TLP. It sits between the RX TLP processing front end, the VC header/data RAMs and the flow-control credit update logic.

## Interface
- NUM_CH, 3: number of queues; queue index width CH_W = $clog2(NUM_CH), minimum 1.
- HDR_AW, 7: header RAM address width per queue; header pointers are HDR_AW+1 bits.
- DATA_AW, 10: data RAM address width per queue; data pointers are DATA_AW+1 bits.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_n_rst  in  1  asynchronous, active-low reset.
- i_w_ch  in  CH_W  target queue; sampled when i_w_sop=1.
- i_w_sop  in  1  header write cycle; starts a TLP.
- i_w_data_valid  in  1  one data word is written this cycle.
- i_w_eop  in  1  last cycle of the TLP.
- i_w_good  in  1  qualifies i_w_eop: 1 = commit, 0 = discard.
- o_w_hdr_en / o_w_data_en  out  1  RAM write enables.
- o_w_hdr_addr  out  CH_W+HDR_AW  {queue, speculative hdr ptr[HDR_AW-1:0]}.
- o_w_data_addr  out  CH_W+DATA_AW  {queue, speculative data ptr[DATA_AW-1:0]}.
- o_ovf_err  out  1  one-cycle pulse on the eop of a TLP that overflowed.
- i_r_hdr_inc / i_r_data_inc  in  NUM_CH  per-queue read pops.
- o_r_hdr_addr  out  NUM_CH*HDR_AW  flattened read pointers, queue 0 in the LSBs.
- o_r_data_addr  out  NUM_CH*DATA_AW  flattened read pointers.
- o_hdr_empty / o_hdr_full / o_data_empty / o_data_full  out  NUM_CH  per-queue flags.
- o_data_free  out  NUM_CH*(DATA_AW+1)  free data words per queue, measured against the speculative write pointer.
- o_fc_hdr_rel / o_fc_data_rel  out  NUM_CH  registered pulses, one per accepted read pop (credit return).

## Operation
- Per-queue registers:
  - committed write pointers: wc_hdr, wc_data
  - speculative write pointers: ws_hdr, ws_data
  - read pointers: r_hdr, r_data
- Write FSM with three states:
  - W_IDLE, on i_w_sop:
    - latch the queue index.
    - If header not full: o_w_hdr_en=1, ws_hdr+1, go to W_ACTIVE.
    - Else: o_w_hdr_en=0, set the ovf flag, go to W_DROP.
  - W_ACTIVE, on i_w_data_valid:
    - If data not full: o_w_data_en=1, ws_data+1.
    - Else: no write, go to W_DROP.
  - W_DROP: every write enable is 0.
- On i_w_eop, from any state:
  - If i_w_good=1 and no overflow: commit, wc<=ws for both header and data, then go to W_IDLE.
  - Otherwise: rollback, ws<=wc, o_ovf_err=1 if the overflow flag was set, then go to W_IDLE.
- sop and eop in the same cycle (header-only TLP) is legal. The header write and the commit happen in that one cycle.
- i_w_data_valid or i_w_eop in W_IDLE without sop is ignored.
- Full flags compare ws against r: MSBs differ and the lower bits are equal. This guarantees a speculative TLP never overwrites unread entries.
- Empty flags compare wc against r: the reader never sees uncommitted entries.
- Reads: r+1 only when inc=1 and the queue is not empty; the same qualified pop drives the fc_rel pulse.
- o_data_free = 2^DATA_AW − (ws_data − r_data), computed modulo 2^(DATA_AW+1).
- All pointers wrap naturally at 2^(AW+1); no saturation.

## Timing
- Reset (async assert): every pointer, the FSM and the ovf flag return to 0 / W_IDLE.
  - o_*_empty=all 1, o_*_full=0, o_data_free=2^DATA_AW per queue.
  - Enables, o_ovf_err and fc_rel pulses are 0.
  - Reset mid-TLP discards the TLP.
- Write enables and addresses are combinational from registered state and same-cycle inputs. The RAM writes at the edge that ends the cycle.
- A commit is visible one cycle after the eop edge: o_*_empty deasserts in cycle eop+1.
- A rollback restores the full flags and o_data_free in cycle eop+1.
- Read pop: the pointer and address update in the next cycle; o_fc_*_rel is high in the cycle after the pop.
- Simultaneous read pop and write on the same queue:
  - Both pointers update independently.
  - Full is evaluated with pre-edge values, so a write into a slot being freed in the same cycle is refused.
- A commit and a read pop in the same cycle on the same queue: the pop uses the pre-commit empty flag.

## Test plan
- Reset, then queue 1: sop, 3 data, eop good -> o_w_data_addr sequence {1,0},{1,1},{1,2}. o_hdr_empty[1]=0 and o_data_empty[1]=0 from eop+1; o_data_free[1]=1021.
- TLP to queue 0 with 4 data, eop with i_w_good=0 -> no empty change; ws_data[0] restored (o_data_free[0]=1024 at eop+1); the next TLP's first address is {0,0}.
- Fill header queue 2 with 128 committed TLPs -> o_hdr_full[2]=1. The 129th sop gets o_w_hdr_en=0 and o_ovf_err pulses at its eop; queues 0 and 1 are unaffected.
- Commit 1024 data words to queue 0, pop 1, then push 2 in one TLP -> first write accepted, second refused, W_DROP entered. Eop good still rolls back and pulses o_ovf_err.
- Wrap-around: push and pop 300 header-only TLPs on queue 0 -> empty toggles correctly across a pointer MSB flip. Each pop gives one o_fc_hdr_rel pulse, 300 in total.
- Assert i_n_rst mid-TLP with 2 data written -> all outputs take their reset values immediately. A subsequent TLP writes from address 0.
